// File: rtl/mem_burst_initiator.sv
// mem_burst_initiator
//   Accepts single-word or burst requests from a client over a valid/ready
//   handshake and sequences them onto the memory port (address / data_in /
//   access_size / rw / enable / busy / data_out). Read beats stream back to
//   the client; write beats are pulled from the client one per cycle.
//
// Optional feature macro: MEM_INIT_ALIGN_CHECK_EN
//   Defined     : misaligned or out-of-range requests are rejected
//                 (done + err pulse, memory never enabled).
//   Not defined : no check; mem_address[1:0] forced to 00; err tied 0.
//
// Ports
//   clock, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_rw/addr/size      : 1=read 0=write, base byte address, 00/01/10/11 = 1/4/8/16 words
//   wr_data/wr_ready      : write beat data, consumed when wr_ready=1
//   rd_data/rd_valid      : read beat data, valid when rd_valid=1
//   done/err              : end-of-transaction pulse, reject pulse
//   mem_*                 : memory port (address, data_in, access_size, rw,
//                           enable, busy, data_out)
module mem_burst_initiator #(
  parameter logic [31:0] base_addr    = 32'h80020000,
  parameter logic [31:0] memory_depth = 32'h100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic        mem_busy,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        rw_q;
  logic        req_ready_q;
  logic        mem_enable_q;
  logic        rd_valid_q;
  logic        wr_phase_q;
  logic        done_q;

  // Index of the final beat for a given size code.
  function automatic logic [3:0] last_beat(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'd0;
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  logic [31:0] addr_d;

`ifdef MEM_INIT_ALIGN_CHECK_EN
  logic        err_q;
  logic [32:0] lim_end;
  logic [32:0] req_end;
  logic        reject;

  // 33-bit sums so an address near the top of the space cannot wrap past the limit.
  always_comb begin
    lim_end = {1'b0, base_addr} + {1'b0, memory_depth};
    req_end = {1'b0, req_addr} + {26'd0, ({1'b0, last_beat(req_size)} + 5'd1), 2'b00};
    reject  = (req_addr[1:0] != 2'b00) || (req_addr < base_addr) || (req_end > lim_end);
  end

  assign addr_d = req_addr;
  assign err    = err_q;
`else
  // Parameters only matter to the range check; fold them away here.
  logic unused_cfg;
  assign unused_cfg = ^{base_addr, memory_depth, req_addr[1:0]};

  assign addr_d = {req_addr[31:2], 2'b00};
  assign err    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      rw_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_enable_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_phase_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef MEM_INIT_ALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MEM_INIT_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q      <= addr_d;
            size_q      <= req_size;
            rw_q        <= req_rw;
            req_ready_q <= 1'b0;
`ifdef MEM_INIT_ALIGN_CHECK_EN
            if (reject) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              mem_enable_q <= 1'b1;
            end
`else
            state_q      <= S_ISSUE;
            mem_enable_q <= 1'b1;
`endif
          end
        end

        S_ISSUE: begin
          if (!mem_busy) begin
            mem_enable_q <= 1'b0;
            if (rw_q) begin
              state_q    <= S_READ;
              rd_valid_q <= 1'b1;
              cnt_q      <= '0;
            end else if (size_q == 2'b00) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              // Beat 0 went out with the issue cycle; WRITE carries beats 1..N-1.
              state_q    <= S_WRITE;
              wr_phase_q <= 1'b1;
              cnt_q      <= 4'd1;
            end
          end
        end

        S_READ: begin
          if (cnt_q == last_beat(size_q)) begin
            state_q    <= S_DONE;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_WRITE: begin
          if (cnt_q == last_beat(size_q)) begin
            state_q    <= S_DONE;
            wr_phase_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          cnt_q       <= '0;
        end

        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          mem_enable_q <= 1'b0;
          rd_valid_q   <= 1'b0;
          wr_phase_q   <= 1'b0;
          cnt_q        <= '0;
        end
      endcase
    end
  end

  // Beat 0 of a write is consumed in the issue cycle only once memory accepts it.
  assign wr_ready        = wr_phase_q | (mem_enable_q & ~rw_q & ~mem_busy);
  assign mem_data_in     = wr_ready ? wr_data : '0;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_valid_q ? mem_data_out : '0;
  assign req_ready       = req_ready_q;
  assign done            = done_q;
  assign mem_enable      = mem_enable_q;
  assign mem_address     = addr_q;
  assign mem_access_size = size_q;
  assign mem_rw          = rw_q;

endmodule

// File: doc/mem_burst_initiator.md
# mem_burst_initiator

Initiator for the pipeline's memory port protocol (address / data_in / access_size / rw / enable / busy / data_out). It accepts single-word or burst requests from a client over a valid/ready handshake and sequences them onto a `memory` instance. Read beats are streamed back to the client and write beats are pulled from it. It sits between a client (data-side load/store path or a cache refill engine) and the memory, in the direction opposite to the memory's responder role.

## Interface
Parameters:
- `base_addr`, default 32'h80020000: lowest valid memory address; used only by the alignment/range check.
- `memory_depth`, default 32'h100000: memory size in bytes; used only by the range check.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  initiator can accept a request; high only in IDLE.
- `req_rw`  in  1  1 = read, 0 = write. Same encoding as memory `rw`.
- `req_addr`  in  32  burst base byte address.
- `req_size`  in  2  00 = 1 word, 01 = 4, 10 = 8, 11 = 16 words.
- `wr_data`  in  32  write beat data.
- `wr_ready`  out  1  current `wr_data` is consumed this cycle.
- `rd_data`  out  32  read beat data.
- `rd_valid`  out  1  `rd_data` valid this cycle.
- `done`  out  1  one-cycle pulse at end of a transaction.
- `err`  out  1  one-cycle pulse with `done` on a rejected request (macro only; otherwise tied 0).
- `mem_address`  out  32  to memory `address`.
- `mem_data_in`  out  32  to memory `data_in`.
- `mem_access_size`  out  2  to memory `access_size`.
- `mem_rw`  out  1  to memory `rw`.
- `mem_enable`  out  1  to memory `enable`.
- `mem_busy`  in  1  from memory `busy`.
- `mem_data_out`  in  32  from memory `data_out`.

## Operation
- States: IDLE, ISSUE, READ, WRITE, DONE.
- IDLE: `req_ready`=1. On `req_valid`, latch addr/size/rw and go to ISSUE. The beat count is N = 1/4/8/16.
- ISSUE: `mem_enable`=1 and latched address/size/rw are driven.
  - If `mem_busy`=1, stay in ISSUE and keep holding the request.
  - If `mem_busy`=0 on a read, go to READ.
  - If `mem_busy`=0 on a write, `mem_data_in`=`wr_data` and `wr_ready`=1 for beat 0. Go to WRITE if N>1, else to DONE.
  - If `mem_busy`=1 on a write, `wr_ready`=0 (the beat is not consumed).
- READ: `rd_valid`=1 and `rd_data`=`mem_data_out` (combinational) for N consecutive cycles. A 4-bit beat counter runs 0..N-1; at N-1, go to DONE.
- WRITE: `wr_ready`=1 and `mem_data_in`=`wr_data` for beats 1..N-1; at N-1, go to DONE. The client must present the next beat every cycle. There is no back-pressure from the client.
- DONE: `done`=1 for one cycle, then IDLE.
- The memory increments addresses internally. `mem_address` holds the base address for the whole transaction.
- `mem_enable`=0 outside ISSUE. `mem_data_in`=0 when not writing.
- Reset values: `req_ready`=1 (state IDLE); all other outputs 0; counter 0; latched fields 0.
- Reset asserted mid-transaction: the burst is abandoned immediately and outputs return to reset values. The memory-side burst is not completed.
- `req_valid` while not IDLE is ignored (`req_ready`=0).

## Timing
- Read of N words, request accepted at edge 0: ISSUE in cycle 1, beats in cycles 2..N+1, `done` in cycle N+2, `req_ready` in cycle N+3.
- Write of N words: ISSUE in cycle 1 (beat 0), beats in cycles 2..N, `done` in cycle N+1.
- Each `mem_busy` cycle during ISSUE adds one cycle. No other stalls occur.
- Back-to-back throughput is one transaction per N+3 cycles for a read and N+2 for a write.

## Configuration
- `MEM_INIT_ALIGN_CHECK_EN` defined:
  - A request is rejected if `req_addr[1:0]`≠0, if `req_addr` < `base_addr`, or if `req_addr` + 4N > `base_addr` + `memory_depth`.
  - A rejected request goes IDLE→DONE with `err`=1 alongside `done`. `mem_enable` is never asserted.
- Not defined: no check is made. `mem_address[1:0]` is forced to 00. `err` is tied 0.

## Test plan
- Reset, then read size 00 at 32'h80020000 with the memory holding 32'h27bdfff8: `rd_valid` for one cycle (cycle 2) with that data, `done` in cycle 3.
- Read size 01 at 32'h80020010: four consecutive `rd_valid` beats in memory order, `mem_enable` high in exactly one cycle, `done` in cycle 6.
- Write size 10 of data 1..8 at 32'h80020100: `wr_ready` for 8 consecutive cycles; a subsequent read size 10 returns 1..8.
- Hold `mem_busy`=1 for 3 cycles during ISSUE of a size-00 read: `mem_enable` stays high for 4 cycles, `done` in cycle 6.
- Assert `reset` during beat 5 of a size-11 read: all outputs are 0 and `req_ready`=1 immediately. A new size-00 read then completes normally.
- With `MEM_INIT_ALIGN_CHECK_EN`, request at 32'h80020002: `done`=1 and `err`=1 in cycle 1, and `mem_enable` is never asserted.
